// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch timebase.
package stopwatch_pkg;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned MS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] minute;
        logic [CNT_W-1:0] second;
        logic [CNT_W-1:0] msecond;
    } sw_time_t;

    localparam sw_time_t TIME_ZERO = '0;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses and time outputs of the stopwatch; LAP_EN adds lap / lap_hold.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic             start_stop;
    logic             clear;
    logic [CNT_W-1:0] minute;
    logic [CNT_W-1:0] second;
    logic [CNT_W-1:0] msecond;
    logic             running;
    logic             wrap;
`ifdef LAP_EN
    logic             lap;
    logic             lap_hold;

    modport master (output start_stop, clear, lap,
                    input  minute, second, msecond, running, wrap, lap_hold);
    modport slave  (input  start_stop, clear, lap,
                    output minute, second, msecond, running, wrap, lap_hold);
`else
    modport master (output start_stop, clear,
                    input  minute, second, msecond, running, wrap);
    modport slave  (input  start_stop, clear,
                    output minute, second, msecond, running, wrap);
`endif

endinterface

// File: rtl/stopwatch_counter_tick_gen.sv
// Prescaler: divides clk by CLK_HZ/TICK_HZ while enabled, holding phase when not.
module tick_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             at_top;

    assign at_top = (div_cnt == DIV_W'(DIV - 1));
    assign tick   = en && !clr && at_top;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= at_top ? '0 : div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch: run/pause/clear FSM with minute:second:centisecond counters.
// Optional LAP_EN adds a lap snapshot that freezes the displayed time.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned MIN_MAX = 99
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_counter_if.slave  bus
);

    state_e   state_q, state_d;
    sw_time_t live_q, live_d;
    logic     tick;
    logic     wrap_d;
    logic     running_q;
    logic     wrap_q;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (state_q == ST_RUN),
        .clr (bus.clear),
        .tick(tick)
    );

    // Clear has priority over start_stop from every state.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else if (bus.start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Cascaded counters; wrap flags the full rollover to zero.
    always_comb begin
        live_d = live_q;
        wrap_d = 1'b0;
        if (bus.clear) begin
            live_d = TIME_ZERO;
        end else if (tick) begin
            if (live_q.msecond != CNT_W'(MS_MAX)) begin
                live_d.msecond = live_q.msecond + CNT_W'(1);
            end else begin
                live_d.msecond = '0;
                if (live_q.second != CNT_W'(SEC_MAX)) begin
                    live_d.second = live_q.second + CNT_W'(1);
                end else begin
                    live_d.second = '0;
                    if (live_q.minute != CNT_W'(MIN_MAX)) begin
                        live_d.minute = live_q.minute + CNT_W'(1);
                    end else begin
                        live_d.minute = '0;
                        wrap_d        = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            live_q    <= TIME_ZERO;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            running_q <= (state_d == ST_RUN);
            wrap_q    <= wrap_d;
        end
    end

    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;

`ifdef LAP_EN
    sw_time_t disp_q;
    logic     lap_hold_q, lap_hold_d, lap_acc;

    assign lap_acc = bus.lap && !bus.clear && (state_q != ST_IDLE);

    always_comb begin
        lap_hold_d = lap_hold_q;
        if (bus.clear) begin
            lap_hold_d = 1'b0;
        end else if (lap_acc) begin
            lap_hold_d = !lap_hold_q;
        end
    end

    // Display freezes on the snapshot while held, otherwise follows live counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q     <= TIME_ZERO;
            lap_hold_q <= 1'b0;
        end else begin
            lap_hold_q <= lap_hold_d;
            if (lap_acc && !lap_hold_q) begin
                disp_q <= live_q;
            end else if (!lap_hold_d) begin
                disp_q <= live_d;
            end
        end
    end

    assign bus.minute   = disp_q.minute;
    assign bus.second   = disp_q.second;
    assign bus.msecond  = disp_q.msecond;
    assign bus.lap_hold = lap_hold_q;
`else
    assign bus.minute   = live_q.minute;
    assign bus.second   = live_q.second;
    assign bus.msecond  = live_q.msecond;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench: DIV=10 instance for control behaviour, DIV=2 / MIN_MAX=1 for rollover.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    stopwatch_counter_if bus ();
    stopwatch_counter_if fbus ();

    stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_MAX(99)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    stopwatch_counter #(.CLK_HZ(200), .TICK_HZ(100), .MIN_MAX(1)) u_fast (
        .clk(clk), .rst(rst), .bus(fbus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hms(input int m, input int s, input int c);
        return {8'h00, 8'(m), 8'(s), 8'(c)};
    endfunction

    function automatic logic [31:0] tmain();
        return {8'h00, bus.minute, bus.second, bus.msecond};
    endfunction

    function automatic logic [31:0] tfast();
        return {8'h00, fbus.minute, fbus.second, fbus.msecond};
    endfunction

    function automatic logic [31:0] fmain();
        return {30'd0, bus.running, bus.wrap};
    endfunction

    function automatic logic [31:0] ffast();
        return {30'd0, fbus.running, fbus.wrap};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_main(input logic ss, input logic clr);
        bus.start_stop = ss;
        bus.clear      = clr;
        step(1);
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
    endtask

    task automatic pulse_fast(input logic ss, input logic clr);
        fbus.start_stop = ss;
        fbus.clear      = clr;
        step(1);
        fbus.start_stop = 1'b0;
        fbus.clear      = 1'b0;
    endtask

`ifdef LAP_EN
    task automatic pulse_lap();
        bus.lap = 1'b1;
        step(1);
        bus.lap = 1'b0;
    endtask
`endif

    initial begin
        bus.start_stop  = 1'b0;
        bus.clear       = 1'b0;
        fbus.start_stop = 1'b0;
        fbus.clear      = 1'b0;
`ifdef LAP_EN
        bus.lap  = 1'b0;
        fbus.lap = 1'b0;
`endif
        step(2);
        exp_q.push_back(hms(0, 0, 0));
        exp_q.push_back(32'd0);
        check("reset_time", tmain(), exp_q.pop_front());
        check("reset_flags", fmain(), exp_q.pop_front());
        rst = 1'b1;
        step(2);

        // First tick lands exactly DIV cycles after the accepted pulse.
        exp_q.push_back(hms(0, 0, 0));
        exp_q.push_back(32'd2);
        exp_q.push_back(hms(0, 0, 1));
        exp_q.push_back(hms(0, 0, 25));
        exp_q.push_back(32'd2);
        pulse_main(1'b1, 1'b0);
        step(9);
        check("pre_tick", tmain(), exp_q.pop_front());
        check("run_flags", fmain(), exp_q.pop_front());
        step(1);
        check("first_tick", tmain(), exp_q.pop_front());
        step(240);
        check("run_250", tmain(), exp_q.pop_front());
        check("run_250_flags", fmain(), exp_q.pop_front());

        // Asynchronous reset mid-cycle, observed before any clock edge.
        exp_q.push_back(hms(0, 0, 0));
        exp_q.push_back(32'd0);
        step(7);
        #2 rst = 1'b0;
        #1;
        check("async_rst_time", tmain(), exp_q.pop_front());
        check("async_rst_flags", fmain(), exp_q.pop_front());
        step(1);
        rst = 1'b1;
        step(1);

        // Pause at msecond 7 with 4 sub-tick cycles banked, then resume.
        exp_q.push_back(hms(0, 0, 7));
        exp_q.push_back(hms(0, 0, 7));
        exp_q.push_back(32'd0);
        exp_q.push_back(hms(0, 0, 7));
        exp_q.push_back(32'd2);
        exp_q.push_back(hms(0, 0, 7));
        exp_q.push_back(hms(0, 0, 8));
        pulse_main(1'b1, 1'b0);
        step(70);
        check("reach_7", tmain(), exp_q.pop_front());
        step(3);
        pulse_main(1'b1, 1'b0);
        check("pause_time", tmain(), exp_q.pop_front());
        check("pause_flags", fmain(), exp_q.pop_front());
        step(500);
        check("pause_hold", tmain(), exp_q.pop_front());
        pulse_main(1'b1, 1'b0);
        check("resume_flags", fmain(), exp_q.pop_front());
        step(5);
        check("resume_pre", tmain(), exp_q.pop_front());
        step(1);
        check("resume_tick", tmain(), exp_q.pop_front());

        // Clear beats start_stop in the same cycle; nothing counts afterwards.
        exp_q.push_back(hms(0, 0, 0));
        exp_q.push_back(32'd0);
        exp_q.push_back(hms(0, 0, 0));
        exp_q.push_back(32'd0);
        step(33);
        pulse_main(1'b1, 1'b1);
        check("clr_win_time", tmain(), exp_q.pop_front());
        check("clr_win_flags", fmain(), exp_q.pop_front());
        step(50);
        check("idle_time", tmain(), exp_q.pop_front());
        check("idle_flags", fmain(), exp_q.pop_front());

`ifdef LAP_EN
        exp_q.push_back(hms(0, 1, 20));
        exp_q.push_back(hms(0, 1, 20));
        exp_q.push_back(32'd1);
        exp_q.push_back(hms(0, 1, 20));
        exp_q.push_back(32'd1);
        exp_q.push_back(hms(0, 1, 50));
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        pulse_main(1'b1, 1'b0);
        step(1200);
        check("lap_live", tmain(), exp_q.pop_front());
        pulse_lap();
        check("lap_snap", tmain(), exp_q.pop_front());
        check("lap_hold_set", 32'(bus.lap_hold), exp_q.pop_front());
        step(300);
        check("lap_frozen", tmain(), exp_q.pop_front());
        check("lap_hold_kept", 32'(bus.lap_hold), exp_q.pop_front());
        pulse_lap();
        check("lap_release", tmain(), exp_q.pop_front());
        check("lap_hold_clr", 32'(bus.lap_hold), exp_q.pop_front());
        pulse_main(1'b0, 1'b1);
        pulse_lap();
        check("lap_idle", 32'(bus.lap_hold), exp_q.pop_front());
`endif

        // Rollover on the fast instance: minute carry, then full wrap with MIN_MAX=1.
        exp_q.push_back(hms(0, 59, 99));
        exp_q.push_back(hms(1, 0, 0));
        exp_q.push_back(32'd2);
        exp_q.push_back(hms(1, 59, 99));
        exp_q.push_back(hms(0, 0, 0));
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
        pulse_fast(1'b1, 1'b0);
        step(11998);
        check("pre_min_carry", tfast(), exp_q.pop_front());
        step(2);
        check("min_carry", tfast(), exp_q.pop_front());
        check("min_carry_flags", ffast(), exp_q.pop_front());
        step(11998);
        check("pre_wrap", tfast(), exp_q.pop_front());
        step(2);
        check("wrap_time", tfast(), exp_q.pop_front());
        check("wrap_flags", ffast(), exp_q.pop_front());
        step(1);
        check("wrap_one_cycle", ffast(), exp_q.pop_front());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
